// File: rtl/piezo_tone_scheduler_pkg.sv
// Shared types for the piezo tone scheduler: FSM states, note codes,
// the 1 MHz half-period table and the per-source melody ROM.
package piezo_tone_scheduler_pkg;

    localparam int SRC_W = 2;   // width of a source index
    localparam int HP_W  = 11;  // width of a half-period count

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_t;

    typedef enum logic [3:0] {
        NOTE_REST = 4'd0,
        NOTE_C4   = 4'd1,
        NOTE_D4   = 4'd2,
        NOTE_E4   = 4'd3,
        NOTE_F4   = 4'd4,
        NOTE_G4   = 4'd5,
        NOTE_A4   = 4'd6,
        NOTE_B4   = 4'd7,
        NOTE_C5   = 4'd8
    } note_t;

    typedef struct packed {
        note_t      code;
        logic [1:0] dur;   // duration in units; 0 terminates the melody
    } mel_entry_t;

    // Half period in clk cycles at 1 MHz; a rest returns 0 (no toggling).
    function automatic logic [HP_W-1:0] note_half_period(input note_t code);
        logic [HP_W-1:0] hp;
        case (code)
            NOTE_C4: hp = 11'd1911;
            NOTE_D4: hp = 11'd1703;
            NOTE_E4: hp = 11'd1517;
            NOTE_F4: hp = 11'd1432;
            NOTE_G4: hp = 11'd1276;
            NOTE_A4: hp = 11'd1136;
            NOTE_B4: hp = 11'd1012;
            NOTE_C5: hp = 11'd956;
            default: hp = 11'd0;
        endcase
        return hp;
    endfunction

    // Melody ROM: up to four notes per source.
    function automatic mel_entry_t melody(input logic [SRC_W-1:0] src, input logic [1:0] idx);
        mel_entry_t e;
        case ({src, idx})
            4'b00_00: e = '{code: NOTE_C5,   dur: 2'd1};
            4'b01_00: e = '{code: NOTE_E4,   dur: 2'd1};
            4'b01_01: e = '{code: NOTE_G4,   dur: 2'd1};
            4'b10_00: e = '{code: NOTE_C4,   dur: 2'd1};
            4'b10_01: e = '{code: NOTE_E4,   dur: 2'd1};
            4'b10_10: e = '{code: NOTE_G4,   dur: 2'd1};
            4'b10_11: e = '{code: NOTE_C5,   dur: 2'd2};
            4'b11_00: e = '{code: NOTE_B4,   dur: 2'd1};
            4'b11_01: e = '{code: NOTE_REST, dur: 2'd1};
            4'b11_10: e = '{code: NOTE_B4,   dur: 2'd1};
            4'b11_11: e = '{code: NOTE_REST, dur: 2'd1};
            default:  e = '{code: NOTE_REST, dur: 2'd0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/piezo_tone_scheduler_if.sv
// Request/status bundle between the sound sources and the tone scheduler.
interface piezo_tone_scheduler_if
    import piezo_tone_scheduler_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic             mute;
    logic             piezo;
    logic             busy;
    logic [SRC_W-1:0] active_src;
    logic             done;

    modport master (
        output req, mute,
        input  piezo, busy, active_src, done
    );

    modport slave (
        input  req, mute,
        output piezo, busy, active_src, done
    );
endinterface

// File: rtl/piezo_tone_scheduler_tone_gen.sv
// Reloadable square-wave generator: latches a half period on load, starts
// low and toggles every half_period cycles while run is high.
module tone_gen
    import piezo_tone_scheduler_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [HP_W-1:0] half_period,
    input  logic            run,
    output logic            wave
);
    logic [HP_W-1:0] hp_q, hp_d;
    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            wave_q, wave_d;

    // Reload on note start, count down while running, park low otherwise.
    always_comb begin
        hp_d   = hp_q;
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (load) begin
            hp_d   = half_period;
            cnt_d  = half_period - HP_W'(1);
            wave_d = 1'b0;
        end else if (run && hp_q != '0) begin
            if (cnt_q == '0) begin
                cnt_d  = hp_q - HP_W'(1);
                wave_d = ~wave_q;
            end else begin
                cnt_d = cnt_q - HP_W'(1);
            end
        end else begin
            wave_d = 1'b0;
        end
    end

    // Counter and wave state.
    always_ff @(posedge clk) begin
        if (rst) begin
            hp_q   <= '0;
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            hp_q   <= hp_d;
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;
endmodule

// File: rtl/piezo_tone_scheduler.sv
// Piezo tone scheduler: latches one-shot sound requests, grants by fixed
// priority (highest index wins) and plays the granted source's melody.
module piezo_tone_scheduler
    import piezo_tone_scheduler_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int UNIT_CYC = 100000,
    parameter int GAP_CYC  = 5000
)(
    input logic                   clk,
    input logic                   rst,
    piezo_tone_scheduler_if.slave bus
);
    localparam int               CNT_W    = $clog2(UNIT_CYC * 3);
    localparam logic [SRC_W-1:0] TOP_SRC  = SRC_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] eff;
    logic             grant_vld;
    logic [SRC_W-1:0] grant_src;
    logic             preempt;
    logic             take;
    logic [SRC_W-1:0] start_src;
    mel_entry_t       start_ent;
    mel_entry_t       next_ent;
    logic             tone_load;
    logic [HP_W-1:0]  tone_hp;
    logic             wave;

    function automatic logic [CNT_W-1:0] dur_cycles(input logic [1:0] dur);
        return CNT_W'(dur) * CNT_W'(UNIT_CYC) - CNT_W'(1);
    endfunction

    // Fixed-priority arbitration over latched plus same-cycle requests.
    always_comb begin
        eff       = pending_q | bus.req;
        grant_vld = 1'b0;
        grant_src = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (eff[i]) begin
                grant_vld = 1'b1;
                grant_src = SRC_W'(i);
            end
        end
        preempt   = (state_q == ST_PLAY || state_q == ST_GAP) &&
                    bus.req[N_REQ-1] && (src_q < TOP_SRC);
        take      = (state_q == ST_IDLE && grant_vld) || preempt;
        start_src = preempt ? TOP_SRC : grant_src;
        start_ent = melody(start_src, 2'd0);
        next_ent  = melody(src_q, idx_q + 2'd1);
    end

    // Pending bits: a grant consumes the bit unless it was already latched
    // and a fresh request for the same source lands in the grant cycle.
    always_comb begin
        pending_d = pending_q | bus.req;
        if (take) begin
            pending_d[start_src] = pending_q[start_src] & bus.req[start_src];
        end
    end

    // Next-state logic, note sequencing and tone reload.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tone_load = 1'b0;
        tone_hp   = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d   = ST_PLAY;
                    src_d     = start_src;
                    idx_d     = 2'd0;
                    cnt_d     = dur_cycles(start_ent.dur);
                    tone_load = 1'b1;
                    tone_hp   = note_half_period(start_ent.code);
                end
            end
            ST_PLAY: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (idx_q == 2'd3 || next_ent.dur == 2'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_PLAY;
                        idx_d     = idx_q + 2'd1;
                        cnt_d     = dur_cycles(next_ent.dur);
                        tone_load = 1'b1;
                        tone_hp   = note_half_period(next_ent.code);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                src_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        // The top-priority source abandons a lower melody and restarts at note 0.
        if (preempt) begin
            state_d   = ST_PLAY;
            src_d     = TOP_SRC;
            idx_d     = 2'd0;
            cnt_d     = dur_cycles(start_ent.dur);
            tone_load = 1'b1;
            tone_hp   = note_half_period(start_ent.code);
        end
    end

    // State register; reset returns everything to idle and drops pending requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            src_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            src_q     <= src_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    tone_gen u_tone_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (tone_load),
        .half_period (tone_hp),
        .run         (state_q == ST_PLAY),
        .wave        (wave)
    );

    // Outputs decoded from state; mute gates only the pin, never the sequencing.
    always_comb begin
        bus.busy       = (state_q == ST_PLAY) || (state_q == ST_GAP);
        bus.done       = (state_q == ST_DONE) || preempt;
        bus.active_src = bus.busy ? src_q : '0;
        bus.piezo      = (state_q == ST_PLAY) && wave && !bus.mute;
    end
endmodule
